knn_vote: RTL and testbench
===========================

# knn_vote

Majority-vote stage of the KNN classifier, directly downstream of the distance sorter. It captures the sorted neighbour-type array when the sorter signals `valid_sort`. It builds a per-class histogram over the K nearest entries, one entry per cycle, then scans the classes one per cycle to pick the winner. It outputs the predicted class, its vote count and a one-cycle `valid_class` strobe.

## Interface
- `L`, 16, number of entries in the sorted array (same as the sorter).
- `TYPE_W`, 3, width of one type/class field. Classes are 0..2^TYPE_W-1; class 0 means "no class".
- `K`, 5, number of nearest neighbours voted. Legal range 1 ≤ K ≤ L.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_sort`  in  1  sorter result-valid level. A start is its rising edge.
- `type_array_sorted`  in  TYPE_W*L  sorted types. Entry i is at bits [(i+1)*TYPE_W-1 -: TYPE_W]; entry 0 is the nearest.
- `class_out`  out  TYPE_W  winning class, registered.
- `vote_count`  out  $clog2(K+1)  number of votes for `class_out`, registered.
- `valid_class`  out  1  one-cycle strobe: new `class_out`/`vote_count` are valid.
- `busy`  out  1  high whenever state ≠ IDLE.
- `overrun`  out  1  sticky flag: a start was dropped. Cleared only by `rst`.

## Operation
- Edge detect: `vs_d` is registered `valid_sort` and resets to 0. `start = valid_sort & ~vs_d`. A level held high after reset therefore counts as one start.
- FSM states: IDLE, COUNT, SELECT, DONE.
- IDLE, when `start`:
  - latch `type_array_sorted`;
  - clear histogram `hist[c]` (width $clog2(K+1)) to 0 and `first[c]` to K for all c;
  - set idx = 0;
  - go to COUNT.
- COUNT, one entry per edge, for idx = 0..K-1, with t = type of entry idx:
  - if t ≠ 0: `hist[t] += 1`, and if `first[t] == K` then `first[t] = idx`;
  - if t = 0: the entry is ignored.
  - After idx = K-1, go to SELECT with c = 1, best = 0, bcnt = 0, bfirst = K.
  - Entries K..L-1 are never examined.
- SELECT, one class per edge, for c = 1..2^TYPE_W-1:
  - take c as best if `hist[c] > bcnt`;
  - or if `hist[c] == bcnt` and `hist[c] > 0` and `first[c] < bfirst`.
  - Tie rule: among equal counts, the class whose nearest member has the lowest sorted index wins.
  - On the last class, register `class_out` and `vote_count` from the final best, set `valid_class` = 1, go to DONE.
- DONE: one cycle. Clear `valid_class`, go to IDLE.
- `class_out`/`vote_count` hold their values until the next DONE or reset.
- A `start` seen in COUNT, SELECT or DONE is dropped (no capture) and sets `overrun` = 1. The current vote continues unaffected.
- All K entries of type 0 gives `class_out` = 0, `vote_count` = 0, with a normal `valid_class` strobe.
- Counters cannot overflow: the histogram width holds K.

## Timing
- Reset values: state IDLE, `class_out` 0, `vote_count` 0, `valid_class` 0, `busy` 0, `overrun` 0, `vs_d` 0, histogram 0.
- A reset mid-operation aborts the vote with no strobe. The block is ready for a start on the first edge after `rst` falls.
- Let capture edge be E0. Edges E1..EK run COUNT. Edges EK+1..EK+2^TYPE_W-1 run SELECT.
- `valid_class` goes high after edge E(K+2^TYPE_W-1) and stays high for exactly one cycle. With defaults: high after E12, low after E13.
- `busy` is high from after E0 through the DONE cycle.
- The earliest next accepted start is at E(K+2^TYPE_W+1), which is E14 with defaults.
- Throughput: one classification per K+2^TYPE_W+1 cycles at best.

## Test plan
All scenarios use L=16, TYPE_W=3, K=5.
- Entries 0..4 = 2,2,3,2,5, then pulse `valid_sort` → `valid_class` one cycle, 12 edges after capture; `class_out`=2, `vote_count`=3.
- Tie: entries 0..4 = 3,4,4,3,1 → `class_out`=3, `vote_count`=2 (class 3 first at idx 0, beats class 4 first at idx 1).
- Entries 0..4 = 0 → `class_out`=0, `vote_count`=0, `valid_class` pulse present. Separately: entries 0..4 = 1,1,2,3,4 and entries 5..15 = 4 → `class_out`=1, `vote_count`=2.
- `valid_sort` held high 40 cycles → exactly one `valid_class` pulse, `overrun`=0. A new rising edge at E6 → dropped, `overrun`=1 and sticky, first result unchanged.
- `rst` asserted for one cycle at COUNT idx 3 → next cycle all outputs 0, `busy`=0, no strobe. Then entries 0..4 = 5,5,5,1,1 → `class_out`=5, `vote_count`=3.
- Back-to-back: second start at E14 → accepted, second strobe after E26. A start at E13 → dropped, `overrun`=1.

Source files
------------

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
//  Module   : knn_vote
//  Purpose  : Majority-vote stage of the KNN classifier. It captures the
//             sorted neighbour types, builds a per-class histogram over the
//             K nearest entries, then scans the classes to pick the winner.
//             Among equal counts, the class with the nearest member wins.
//  Revision : 1.0  initial release
// ============================================================================
module knn_vote #(
    parameter int L      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_sort,
    input  logic [TYPE_W*L-1:0]      type_array_sorted,
    output logic [TYPE_W-1:0]        class_out,
    output logic [$clog2(K+1)-1:0]   vote_count,
    output logic                     valid_class,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam int NCLS  = 2 ** TYPE_W;

    localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
    localparam logic [TYPE_W-1:0] LAST_CLS = {TYPE_W{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_SELECT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                vs_q;
    logic [TYPE_W*L-1:0] arr_q, arr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    hist_q  [NCLS];
    logic [CNT_W-1:0]    hist_d  [NCLS];
    logic [CNT_W-1:0]    first_q [NCLS];
    logic [CNT_W-1:0]    first_d [NCLS];
    logic [TYPE_W-1:0]   cls_q, cls_d;
    logic [TYPE_W-1:0]   best_q, best_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic [CNT_W-1:0]    bfirst_q, bfirst_d;
    logic [TYPE_W-1:0]   class_q, class_d;
    logic [CNT_W-1:0]    vote_q, vote_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic                start;
    logic [TYPE_W-1:0]   ent_type;
    logic [TYPE_W-1:0]   ent_w [L];
    logic [CNT_W-1:0]    sel_cnt;
    logic [CNT_W-1:0]    sel_first;
    logic                take;

    // Split the latched array into entries so COUNT can index by idx directly
    for (genvar i = 0; i < L; i++) begin : g_unpack
        assign ent_w[i] = arr_q[(i+1)*TYPE_W-1 -: TYPE_W];
    end

    // A start is the rising edge of the sorter's valid level
    assign start     = valid_sort & ~vs_q;
    assign ent_type  = ent_w[idx_q];
    assign sel_cnt   = hist_q[cls_q];
    assign sel_first = first_q[cls_q];
    // Strictly more votes wins; an equal non-zero count wins only if its
    // nearest member sits at a lower sorted index than the current best
    assign take      = (sel_cnt > bcnt_q) ||
                       ((sel_cnt == bcnt_q) && (sel_cnt != '0) && (sel_first < bfirst_q));

    assign class_out   = class_q;
    assign vote_count  = vote_q;
    assign valid_class = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;

    // Next-state logic for the capture / count / select sequence
    always_comb begin
        state_d  = state_q;
        arr_d    = arr_q;
        idx_d    = idx_q;
        hist_d   = hist_q;
        first_d  = first_q;
        cls_d    = cls_q;
        best_d   = best_q;
        bcnt_d   = bcnt_q;
        bfirst_d = bfirst_q;
        class_d  = class_q;
        vote_d   = vote_q;
        valid_d  = 1'b0;
        // Starts arriving while a vote is running are dropped, not queued
        overrun_d = overrun_q | (start & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    arr_d = type_array_sorted;
                    for (int c = 0; c < NCLS; c++) begin
                        hist_d[c]  = '0;
                        first_d[c] = K_CNT;
                    end
                    idx_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Type 0 means "no class" and casts no vote
                if (ent_type != '0) begin
                    hist_d[ent_type] = hist_q[ent_type] + CNT_W'(1);
                    if (first_q[ent_type] == K_CNT) begin
                        first_d[ent_type] = CNT_W'(idx_q);
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d  = S_SELECT;
                    cls_d    = TYPE_W'(1);
                    best_d   = '0;
                    bcnt_d   = '0;
                    bfirst_d = K_CNT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SELECT: begin
                if (cls_q == LAST_CLS) begin
                    class_d = take ? cls_q   : best_q;
                    vote_d  = take ? sel_cnt : bcnt_q;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (take) begin
                        best_d   = cls_q;
                        bcnt_d   = sel_cnt;
                        bfirst_d = sel_first;
                    end
                    cls_d = cls_q + TYPE_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vs_q      <= 1'b0;
            arr_q     <= '0;
            idx_q     <= '0;
            for (int c = 0; c < NCLS; c++) begin
                hist_q[c]  <= '0;
                first_q[c] <= K_CNT;
            end
            cls_q     <= '0;
            best_q    <= '0;
            bcnt_q    <= '0;
            bfirst_q  <= K_CNT;
            class_q   <= '0;
            vote_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_q      <= valid_sort;
            arr_q     <= arr_d;
            idx_q     <= idx_d;
            hist_q    <= hist_d;
            first_q   <= first_d;
            cls_q     <= cls_d;
            best_q    <= best_d;
            bcnt_q    <= bcnt_d;
            bfirst_q  <= bfirst_d;
            class_q   <= class_d;
            vote_q    <= vote_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
//  Module   : tb_knn_vote
//  Purpose  : Self-checking bench for knn_vote with directed and random votes
//             compared against a simple arithmetic vote model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_knn_vote;

    localparam int LL = 16;
    localparam int TW = 3;
    localparam int KK = 5;

    logic             clk;
    logic             rst;
    logic             valid_sort;
    logic [TW*LL-1:0] type_array_sorted;
    logic [TW-1:0]    class_out;
    logic [2:0]       vote_count;
    logic             valid_class;
    logic             busy;
    logic             overrun;

    int n_checks;
    int n_pass;
    int pulses;

    knn_vote #(.L(LL), .TYPE_W(TW), .K(KK)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_sort        (valid_sort),
        .type_array_sorted (type_array_sorted),
        .class_out         (class_out),
        .vote_count        (vote_count),
        .valid_class       (valid_class),
        .busy              (busy),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge, then observe 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        if (valid_class === 1'b1) pulses++;
    endtask

    // Reference vote: count the K nearest non-zero types, the winner is the
    // type of the nearest entry whose class reaches the maximum count
    function automatic void ref_vote(input logic [TW*LL-1:0] arr, output int cls, output int cnt);
        int counts [8];
        int maxc;
        logic [TW*LL-1:0] a;
        a = arr;
        for (int c = 0; c < 8; c++) counts[c] = 0;
        for (int i = 0; i < KK; i++) begin
            int t;
            t = int'(a[i*TW +: TW]);
            if (t != 0) counts[t]++;
        end
        maxc = 0;
        for (int c = 1; c < 8; c++) if (counts[c] > maxc) maxc = counts[c];
        cls = 0;
        cnt = maxc;
        if (maxc > 0) begin
            for (int i = KK - 1; i >= 0; i--) begin
                int t;
                t = int'(a[i*TW +: TW]);
                if (t != 0 && counts[t] == maxc) cls = t;
            end
        end
    endfunction

    function automatic logic [TW*LL-1:0] pk(input int v0, input int v1, input int v2,
                                            input int v3, input int v4, input int fill);
        logic [TW*LL-1:0] r;
        int v [5];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3; v[4] = v4;
        for (int i = 0; i < LL; i++) r[i*TW +: TW] = TW'((i < 5) ? v[i] : fill);
        return r;
    endfunction

    function automatic logic [TW*LL-1:0] rnd_arr(input int maxt);
        logic [TW*LL-1:0] r;
        for (int i = 0; i < LL; i++) r[i*TW +: TW] = TW'($urandom_range(maxt, 0));
        return r;
    endfunction

    // One full vote starting at the next edge (E0). pulse_edge > 0 raises
    // valid_sort again for the edge of that number to provoke a drop.
    task automatic run_vote(input string tag, input logic [TW*LL-1:0] arr,
                            input int pulse_edge, input logic exp_ovr);
        int ec, en, p0;
        ref_vote(arr, ec, en);
        p0 = pulses;
        type_array_sorted = arr;
        valid_sort = 1'b1;
        step();
        chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
        type_array_sorted = rnd_arr(7);
        for (int e = 1; e <= 13; e++) begin
            valid_sort = (e == pulse_edge);
            step();
            if (e < 12) chk({tag, ".early_valid"}, 32'(valid_class), 32'd0);
            if (e == 12) begin
                chk({tag, ".valid_e12"}, 32'(valid_class), 32'd1);
                chk({tag, ".class"}, 32'(class_out), 32'(ec));
                chk({tag, ".votes"}, 32'(vote_count), 32'(en));
                chk({tag, ".busy_e12"}, 32'(busy), 32'd1);
            end
            if (e == 13) begin
                chk({tag, ".valid_e13"}, 32'(valid_class), 32'd0);
                chk({tag, ".busy_e13"}, 32'(busy), 32'd0);
                chk({tag, ".class_hold"}, 32'(class_out), 32'(ec));
            end
        end
        valid_sort = 1'b0;
        chk({tag, ".pulses"}, 32'(pulses - p0), 32'd1);
        chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int ec, en, p0;
        logic [TW*LL-1:0] arr;
        n_checks = 0;
        n_pass = 0;
        pulses = 0;
        rst = 1'b1;
        valid_sort = 1'b0;
        type_array_sorted = '0;
        step();
        step();
        chk("reset.class", 32'(class_out), 32'd0);
        chk("reset.votes", 32'(vote_count), 32'd0);
        chk("reset.valid", 32'(valid_class), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        step();

        // Directed votes from the test plan
        run_vote("basic", pk(2, 2, 3, 2, 5, 0), 0, 1'b0);
        chk("basic.exp_class", 32'(class_out), 32'd2);
        run_vote("tie", pk(3, 4, 4, 3, 1, 6), 0, 1'b0);
        chk("tie.exp_class", 32'(class_out), 32'd3);
        run_vote("allzero", pk(0, 0, 0, 0, 0, 7), 0, 1'b0);
        chk("allzero.votes", 32'(vote_count), 32'd0);
        run_vote("beyondk", pk(1, 1, 2, 3, 4, 4), 0, 1'b0);
        chk("beyondk.exp_class", 32'(class_out), 32'd1);
        chk("beyondk.exp_votes", 32'(vote_count), 32'd2);

        // Back-to-back: each vote's start lands on E14 of the previous one
        for (int n = 0; n < 24; n++) begin
            run_vote("rand", rnd_arr((n % 3 == 0) ? 2 : 7), 0, 1'b0);
        end

        // Level held high for 40 cycles counts as a single start
        arr = rnd_arr(3);
        ref_vote(arr, ec, en);
        p0 = pulses;
        type_array_sorted = arr;
        valid_sort = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("hold.pulses", 32'(pulses - p0), 32'd1);
        chk("hold.overrun", 32'(overrun), 32'd0);
        chk("hold.class", 32'(class_out), 32'(ec));
        chk("hold.votes", 32'(vote_count), 32'(en));
        valid_sort = 1'b0;
        step();

        // New rising edge at E6 is dropped and flags overrun
        run_vote("drop_e6", pk(2, 2, 3, 2, 5, 1), 6, 1'b1);
        chk("drop_e6.class", 32'(class_out), 32'd2);
        step();
        step();
        chk("drop_e6.sticky", 32'(overrun), 32'd1);
        chk("drop_e6.idle", 32'(busy), 32'd0);

        // Reset during COUNT idx 3 aborts with no strobe
        p0 = pulses;
        type_array_sorted = pk(6, 6, 6, 6, 6, 6);
        valid_sort = 1'b1;
        step();
        valid_sort = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst.class", 32'(class_out), 32'd0);
        chk("midrst.votes", 32'(vote_count), 32'd0);
        chk("midrst.valid", 32'(valid_class), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        run_vote("after_rst", pk(5, 5, 5, 1, 1, 2), 0, 1'b0);
        chk("after_rst.no_strobe", 32'(pulses - p0), 32'd1);
        chk("after_rst.exp_votes", 32'(vote_count), 32'd3);

        // Start at E13 (DONE) is dropped; nothing new begins at E14
        run_vote("drop_e13", pk(4, 1, 4, 2, 0, 3), 13, 1'b1);
        p0 = pulses;
        step();
        chk("drop_e13.idle", 32'(busy), 32'd0);
        for (int i = 0; i < 14; i++) step();
        chk("drop_e13.no_pulse", 32'(pulses - p0), 32'd0);
        chk("drop_e13.class", 32'(class_out), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
